// File: rtl/fram_sp_arb_pkg.sv
// ---------------------------------------------------------------------------
// fram_sp_arb_pkg
// Shared definitions for the two-port arbiter in front of the fram_sp RAM:
// FSM state encoding, requester identifiers, statistics counter width and a
// saturating-increment helper used by the optional statistics block.
// ---------------------------------------------------------------------------
package fram_sp_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } arb_state_t;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_id_t;

    localparam int STATS_W = 16;

    // Increment that sticks at all-ones instead of wrapping to zero.
    function automatic logic [STATS_W-1:0] sat_inc(input logic [STATS_W-1:0] v);
        return (v == {STATS_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/fram_sp_arb_stats.sv
// ---------------------------------------------------------------------------
// fram_sp_arb_stats
// Three saturating event counters for the arbiter: grants to port A, grants
// to port B, and cycles in which both ports requested (so one was refused).
// Only instantiated when FRAM_SP_ARB_STATS_EN is defined.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset (clears counters)
//   stats_clr       synchronous clear, wins over counting
//   a_gnt, b_gnt    grant strobes from the arbiter
//   conflict        both ports requested this cycle
//   a_gnt_cnt, b_gnt_cnt, conflict_cnt   counter values
// ---------------------------------------------------------------------------
module fram_sp_arb_stats
    import fram_sp_arb_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stats_clr,
    input  logic               a_gnt,
    input  logic               b_gnt,
    input  logic               conflict,
    output logic [STATS_W-1:0] a_gnt_cnt,
    output logic [STATS_W-1:0] b_gnt_cnt,
    output logic [STATS_W-1:0] conflict_cnt
);

    // Counters advance on their event and saturate; a clear request in the
    // same cycle as an event discards the event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_gnt_cnt    <= '0;
            b_gnt_cnt    <= '0;
            conflict_cnt <= '0;
        end else if (stats_clr) begin
            a_gnt_cnt    <= '0;
            b_gnt_cnt    <= '0;
            conflict_cnt <= '0;
        end else begin
            if (a_gnt)    a_gnt_cnt    <= sat_inc(a_gnt_cnt);
            if (b_gnt)    b_gnt_cnt    <= sat_inc(b_gnt_cnt);
            if (conflict) conflict_cnt <= sat_inc(conflict_cnt);
        end
    end

endmodule

// File: rtl/fram_sp_arb.sv
// ---------------------------------------------------------------------------
// fram_sp_arb
// Round-robin arbiter and sequencer for two requesters sharing one fram_sp
// single-port RAM. Grants at most one access per cycle, drives the RAM pins
// combinationally from the winner, and returns read data with a per-port
// valid one cycle after the grant. A requester may lock the RAM for a burst
// of up to MAX_LOCK granted cycles.
// Optional build macro: FRAM_SP_ARB_STATS_EN adds grant/conflict counters
// (ports stats_clr, a_gnt_cnt, b_gnt_cnt, conflict_cnt).
// Ports:
//   clk, rst_n                         clock (shared with RAM), async reset
//   {a,b}_req/_we/_lock/_addr/_wdata   requester inputs, held until gnt
//   {a,b}_gnt                          access accepted this cycle
//   {a,b}_rvalid/_rdata                read return, one cycle after grant
//   ram_addr/_wr_data/_wr_en/ram_en    RAM drive
//   ram_rd_data                        RAM read data
// ---------------------------------------------------------------------------
module fram_sp_arb
    import fram_sp_arb_pkg::*;
#(
    parameter int AW       = 10,
    parameter int FPGA_DW  = 8,
    parameter int MAX_LOCK = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               a_req,
    input  logic               a_we,
    input  logic               a_lock,
    input  logic [AW-1:0]      a_addr,
    input  logic [FPGA_DW-1:0] a_wdata,
    output logic               a_gnt,
    output logic               a_rvalid,
    output logic [FPGA_DW-1:0] a_rdata,
    input  logic               b_req,
    input  logic               b_we,
    input  logic               b_lock,
    input  logic [AW-1:0]      b_addr,
    input  logic [FPGA_DW-1:0] b_wdata,
    output logic               b_gnt,
    output logic               b_rvalid,
    output logic [FPGA_DW-1:0] b_rdata,
`ifdef FRAM_SP_ARB_STATS_EN
    input  logic               stats_clr,
    output logic [STATS_W-1:0] a_gnt_cnt,
    output logic [STATS_W-1:0] b_gnt_cnt,
    output logic [STATS_W-1:0] conflict_cnt,
`endif
    output logic [AW-1:0]      ram_addr,
    output logic [FPGA_DW-1:0] ram_wr_data,
    output logic               ram_wr_en,
    output logic               ram_en,
    input  logic [FPGA_DW-1:0] ram_rd_data
);

    localparam logic [8:0] MAX_LOCK_W = 9'(MAX_LOCK);
    // A single-cycle tenure is exhausted by the grant that would open it.
    localparam bit         LOCK_OK    = (MAX_LOCK > 1);

    arb_state_t state_q, state_d;
    port_id_t   rr_last_q, rr_last_d;
    logic [7:0] lock_cnt_q, lock_cnt_d;
    logic [8:0] cnt_inc;
    logic       grant_a, grant_b;
    logic       a_rvalid_q, b_rvalid_q;

    // Grant decision and next-state. In IDLE ties go to the port that did
    // not win last; in OWN_x only x can be served. A tenure ends on an
    // unlocked grant, on the MAX_LOCK-th grant, or when x releases lock
    // while idle. Every grant and every tenure end records rr_last.
    always_comb begin
        grant_a    = 1'b0;
        grant_b    = 1'b0;
        state_d    = state_q;
        rr_last_d  = rr_last_q;
        lock_cnt_d = lock_cnt_q;
        cnt_inc    = {1'b0, lock_cnt_q} + 9'd1;
        case (state_q)
            IDLE: begin
                if (a_req && (!b_req || rr_last_q == PORT_B)) begin
                    grant_a = 1'b1;
                end else if (b_req) begin
                    grant_b = 1'b1;
                end
                if (grant_a) begin
                    rr_last_d = PORT_A;
                    if (a_lock && LOCK_OK) begin
                        state_d    = OWN_A;
                        lock_cnt_d = 8'd1;
                    end
                end else if (grant_b) begin
                    rr_last_d = PORT_B;
                    if (b_lock && LOCK_OK) begin
                        state_d    = OWN_B;
                        lock_cnt_d = 8'd1;
                    end
                end
            end
            OWN_A: begin
                grant_a = a_req;
                if (a_req) begin
                    rr_last_d  = PORT_A;
                    lock_cnt_d = cnt_inc[7:0];
                    if (!a_lock || cnt_inc == MAX_LOCK_W) begin
                        state_d    = IDLE;
                        lock_cnt_d = 8'd0;
                    end
                end else if (!a_lock) begin
                    state_d    = IDLE;
                    rr_last_d  = PORT_A;
                    lock_cnt_d = 8'd0;
                end
            end
            OWN_B: begin
                grant_b = b_req;
                if (b_req) begin
                    rr_last_d  = PORT_B;
                    lock_cnt_d = cnt_inc[7:0];
                    if (!b_lock || cnt_inc == MAX_LOCK_W) begin
                        state_d    = IDLE;
                        lock_cnt_d = 8'd0;
                    end
                end else if (!b_lock) begin
                    state_d    = IDLE;
                    rr_last_d  = PORT_B;
                    lock_cnt_d = 8'd0;
                end
            end
            default: begin
                state_d    = IDLE;
                lock_cnt_d = 8'd0;
            end
        endcase
    end

    // Arbiter state, fairness pointer and lock counter. Reset leaves B as
    // the last winner so A takes the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rr_last_q  <= PORT_B;
            lock_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            rr_last_q  <= rr_last_d;
            lock_cnt_q <= lock_cnt_d;
        end
    end

    // Read-return pipeline: the RAM registers the address on the granted
    // cycle, so its data is valid exactly one cycle later. Reset drops any
    // read still in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
        end else begin
            a_rvalid_q <= a_gnt && !a_we;
            b_rvalid_q <= b_gnt && !b_we;
        end
    end

    // Grants are masked during reset. When B is not granted the RAM address
    // and data buses rest on port A's values to keep toggling low.
    assign a_gnt       = grant_a && rst_n;
    assign b_gnt       = grant_b && rst_n;
    assign ram_en      = a_gnt || b_gnt;
    assign ram_wr_en   = (a_gnt && a_we) || (b_gnt && b_we);
    assign ram_addr    = b_gnt ? b_addr  : a_addr;
    assign ram_wr_data = b_gnt ? b_wdata : a_wdata;
    assign a_rvalid    = a_rvalid_q;
    assign b_rvalid    = b_rvalid_q;
    assign a_rdata     = ram_rd_data;
    assign b_rdata     = ram_rd_data;

`ifdef FRAM_SP_ARB_STATS_EN
    fram_sp_arb_stats u_stats (
        .clk          (clk),
        .rst_n        (rst_n),
        .stats_clr    (stats_clr),
        .a_gnt        (a_gnt),
        .b_gnt        (b_gnt),
        .conflict     (a_req && b_req && rst_n),
        .a_gnt_cnt    (a_gnt_cnt),
        .b_gnt_cnt    (b_gnt_cnt),
        .conflict_cnt (conflict_cnt)
    );
`endif

endmodule

// File: tb/tb_fram_sp_arb.sv
// ---------------------------------------------------------------------------
// tb_fram_sp_arb
// Self-checking bench for fram_sp_arb (MAX_LOCK=4) with a behavioural RAM.
// Directed scenarios followed by randomized traffic; a reference model
// predicts grants and RAM drive, and queues expected read data that a
// separate monitor pops whenever a port presents rvalid.
// ---------------------------------------------------------------------------
module tb_fram_sp_arb;
    import fram_sp_arb_pkg::*;

    localparam int AW = 10;
    localparam int DW = 8;
    localparam int ML = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          a_req, a_we, a_lock, b_req, b_we, b_lock;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_wdata, b_wdata;
    logic          a_gnt, a_rvalid, b_gnt, b_rvalid;
    logic [DW-1:0] a_rdata, b_rdata;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wr_data, ram_rd_data;
    logic          ram_wr_en, ram_en;
`ifdef FRAM_SP_ARB_STATS_EN
    logic               stats_clr;
    logic [STATS_W-1:0] a_gnt_cnt, b_gnt_cnt, conflict_cnt;
`endif

    int compared   = 0;
    int mismatched = 0;

    // Reference model state: owner 0=none 1=A 2=B, last winner 1=A 2=B.
    int            owner, burst, last;
    logic [DW-1:0] mem_model [1024];
    logic [DW-1:0] qa [$];
    logic [DW-1:0] qb [$];
    bit            last_ga, last_gb;
    int            exp_conf;

    // Behavioural RAM: address registered on any enabled access.
    logic [DW-1:0] mem [1024];
    logic [AW-1:0] ram_addr_q;

    always #5 clk = ~clk;

    fram_sp_arb #(.AW(AW), .FPGA_DW(DW), .MAX_LOCK(ML)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_we(a_we), .a_lock(a_lock), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_lock(b_lock), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
`ifdef FRAM_SP_ARB_STATS_EN
        .stats_clr(stats_clr), .a_gnt_cnt(a_gnt_cnt), .b_gnt_cnt(b_gnt_cnt),
        .conflict_cnt(conflict_cnt),
`endif
        .ram_addr(ram_addr), .ram_wr_data(ram_wr_data), .ram_wr_en(ram_wr_en),
        .ram_en(ram_en), .ram_rd_data(ram_rd_data)
    );

    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_wr_en) mem[ram_addr] <= ram_wr_data;
            ram_addr_q <= ram_addr;
        end
    end
    assign ram_rd_data = mem[ram_addr_q];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every rvalid must match the oldest predicted read for that port.
    always @(negedge clk) begin
        if (rst_n) begin
            if (a_rvalid) begin
                if (qa.size() == 0) check("a_rvalid_unexpected", 1, 0);
                else check("a_rdata", a_rdata, qa.pop_front());
            end
            if (b_rvalid) begin
                if (qb.size() == 0) check("b_rvalid_unexpected", 1, 0);
                else check("b_rdata", b_rdata, qb.pop_front());
            end
        end
    end

    task automatic applyStimulus(input logic ar, input logic aw, input logic al,
                                 input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                                 input logic br, input logic bw, input logic bl,
                                 input logic [AW-1:0] ba, input logic [DW-1:0] bd);
        a_req = ar; a_we = aw; a_lock = al; a_addr = aa; a_wdata = ad;
        b_req = br; b_we = bw; b_lock = bl; b_addr = ba; b_wdata = bd;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Model of a granted access: memory effect, read prediction, lock tenure.
    task automatic serve(input int x, input logic we, input logic lk,
                         input logic [AW-1:0] ad, input logic [DW-1:0] wd);
        last = x;
        if (we) mem_model[ad] = wd;
        else if (x == 1) qa.push_back(mem_model[ad]);
        else qb.push_back(mem_model[ad]);
        if (owner == 0) begin
            if (lk && ML > 1) begin
                owner = x;
                burst = 1;
            end
        end else begin
            burst++;
            if (!lk || burst >= ML) owner = 0;
        end
    endtask

    // Predict this cycle's grant from the current inputs, compare the DUT's
    // grant and RAM drive, then advance the model.
    task automatic checkOutput();
        bit ga, gb;
        ga = 0;
        gb = 0;
        #1;
        if (owner == 1) ga = a_req;
        else if (owner == 2) gb = b_req;
        else if (a_req && b_req) begin
            if (last == 1) gb = 1; else ga = 1;
        end else begin
            ga = a_req;
            gb = b_req;
        end
        check("a_gnt", a_gnt, ga);
        check("b_gnt", b_gnt, gb);
        if (ga || gb) begin
            check("ram_en", ram_en, 1);
            check("ram_wr_en", ram_wr_en, ga ? a_we : b_we);
            check("ram_addr", ram_addr, ga ? a_addr : b_addr);
            if (ga ? a_we : b_we) check("ram_wr_data", ram_wr_data, ga ? a_wdata : b_wdata);
        end else begin
            check("ram_en_idle", ram_en, 0);
            check("ram_wr_en_idle", ram_wr_en, 0);
        end
        if (a_req && b_req) exp_conf++;
        if (ga) serve(1, a_we, a_lock, a_addr, a_wdata);
        else if (gb) serve(2, b_we, b_lock, b_addr, b_wdata);
        else if (owner == 1 && !a_lock) begin owner = 0; last = 1; end
        else if (owner == 2 && !b_lock) begin owner = 0; last = 2; end
        last_ga = ga;
        last_gb = gb;
    endtask

    task automatic expectGnt(input string name, input logic ea, input logic eb);
        check({name, "_a"}, a_gnt, ea);
        check({name, "_b"}, b_gnt, eb);
    endtask

    task automatic modelReset();
        qa.delete();
        qb.delete();
        owner = 0;
        burst = 0;
        last = 2;
        exp_conf = 0;
    endtask

    task automatic doReset();
        rst_n = 0;
        applyStimulus(0, 0, 0, '0, '0, 0, 0, 0, '0, '0);
        modelReset();
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1;
        nextCycle();
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem[i] = '0;
            mem_model[i] = '0;
        end
        ram_addr_q = '0;
        rst_n = 0;
`ifdef FRAM_SP_ARB_STATS_EN
        stats_clr = 0;
`endif
        applyStimulus(0, 0, 0, '0, '0, 0, 0, 0, '0, '0);
        modelReset();

        // Reset values
        @(negedge clk);
        check("rst_a_gnt", a_gnt, 0);
        check("rst_b_gnt", b_gnt, 0);
        check("rst_a_rvalid", a_rvalid, 0);
        check("rst_b_rvalid", b_rvalid, 0);
        check("rst_ram_en", ram_en, 0);
        check("rst_ram_wr_en", ram_wr_en, 0);
        doReset();

        // Write 5A to 3, read it back on port A
        applyStimulus(1, 1, 0, 10'd3, 8'h5A, 0, 0, 0, '0, '0);
        checkOutput(); expectGnt("t1_wr", 1, 0);
        nextCycle();
        applyStimulus(1, 0, 0, 10'd3, 8'h00, 0, 0, 0, '0, '0);
        checkOutput(); expectGnt("t1_rd", 1, 0);
        nextCycle();
        applyStimulus(0, 0, 0, '0, '0, 0, 0, 0, '0, '0);
        checkOutput();
        check("t1_a_rvalid", a_rvalid, 1);
        check("t1_a_rdata", a_rdata, 8'h5A);
        check("t1_b_rvalid", b_rvalid, 0);
        nextCycle();

        // Continuous contention alternates starting with A
        doReset();
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1, 0, 0, 10'd1, '0, 1, 0, 0, 10'd2, '0);
            checkOutput();
            expectGnt("t2_alt", (i % 2) == 0, (i % 2) == 1);
            nextCycle();
        end
        applyStimulus(0, 0, 0, '0, '0, 0, 0, 0, '0, '0);
`ifdef FRAM_SP_ARB_STATS_EN
        check("t2_conflict_cnt", conflict_cnt, 6);
        check("t2_a_gnt_cnt", a_gnt_cnt, 3);
`endif
        checkOutput();
        nextCycle();

        // Locked burst capped at MAX_LOCK, then B, then A again
        doReset();
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1, 0, 1, 10'(i), '0, 1, 0, 0, 10'd5, '0);
            checkOutput();
            expectGnt("t3_lock", i != 4, i == 4);
            nextCycle();
        end
        applyStimulus(0, 0, 0, '0, '0, 0, 0, 0, '0, '0);
        checkOutput();
        nextCycle();

        // Ownership held through idle locked cycles
        doReset();
        applyStimulus(1, 0, 1, 10'd9, '0, 1, 0, 0, 10'd6, '0);
        checkOutput(); expectGnt("t4_take", 1, 0);
        nextCycle();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, i < 3, '0, '0, 1, 0, 0, 10'd6, '0);
            checkOutput(); expectGnt("t4_hold", 0, 0);
            nextCycle();
        end
        applyStimulus(0, 0, 0, '0, '0, 1, 0, 0, 10'd6, '0);
        checkOutput(); expectGnt("t4_release", 0, 1);
        nextCycle();
        applyStimulus(0, 0, 0, '0, '0, 0, 0, 0, '0, '0);
        checkOutput();
        nextCycle();

        // Read-after-write on consecutive cycles
        applyStimulus(1, 1, 0, 10'd7, 8'h11, 0, 0, 0, '0, '0);
        checkOutput();
        nextCycle();
        applyStimulus(1, 0, 0, 10'd7, '0, 0, 0, 0, '0, '0);
        checkOutput();
        nextCycle();
        applyStimulus(0, 0, 0, '0, '0, 0, 0, 0, '0, '0);
        checkOutput();
        check("t5_a_rvalid", a_rvalid, 1);
        check("t5_a_rdata", a_rdata, 8'h11);
        nextCycle();

        // Reset right behind a read grant drops the return
        applyStimulus(1, 0, 1, 10'd3, '0, 0, 0, 0, '0, '0);
        checkOutput(); expectGnt("t6_rd", 1, 0);
        #1 rst_n = 0;
        applyStimulus(0, 0, 0, '0, '0, 0, 0, 0, '0, '0);
        modelReset();
        nextCycle();
        check("t6_no_rvalid", a_rvalid, 0);
        @(posedge clk);
        #3 rst_n = 1;
        nextCycle();
        check("t6_still_no_rvalid", a_rvalid, 0);
        applyStimulus(1, 0, 0, 10'd1, '0, 1, 0, 0, 10'd2, '0);
        checkOutput(); expectGnt("t6_tie", 1, 0);
        nextCycle();
        applyStimulus(0, 0, 0, '0, '0, 0, 0, 0, '0, '0);
        checkOutput();
        nextCycle();

        // Randomized traffic
        doReset();
        for (int c = 0; c < 600; c++) begin
            if (!a_req && $urandom_range(0, 99) < 55) begin
                a_req = 1; a_we = 1'($urandom_range(0, 1));
                a_addr = 10'($urandom_range(0, 15)); a_wdata = 8'($urandom);
            end
            if (!b_req && $urandom_range(0, 99) < 55) begin
                b_req = 1; b_we = 1'($urandom_range(0, 1));
                b_addr = 10'($urandom_range(0, 15)); b_wdata = 8'($urandom);
            end
            a_lock = ($urandom_range(0, 99) < 35);
            b_lock = ($urandom_range(0, 99) < 35);
            checkOutput();
            nextCycle();
            if (last_ga) a_req = 0;
            if (last_gb) b_req = 0;
        end
`ifdef FRAM_SP_ARB_STATS_EN
        check("rand_conflict_cnt", conflict_cnt, exp_conf);
`endif
        applyStimulus(0, 0, 0, '0, '0, 0, 0, 0, '0, '0);
        repeat (3) nextCycle();
        check("drain_qa", qa.size(), 0);
        check("drain_qb", qb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
